// File: rtl/conversaodec_bin_seq.sv
// Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method.
// One conversion takes WIDTH iterations. A start/busy/done handshake is used, and
// the result saturates to all nines when it does not fit in DIGITS digits.
module conversaodec_bin_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  // One spare scratch digit lets the converter detect values that do not fit
  localparam int unsigned SD = DIGITS + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     sh, sh_n;
  logic [4*SD-1:0]      scr, scr_n;
  logic [4*SD-1:0]      adj;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 busy_n;
  logic                 done_n;
  logic [4*DIGITS-1:0]  bcd_n;
  logic                 overflow_n;

  // Add-3 correction applied to every scratch digit that is 5 or more
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < SD; i++) begin
      if (scr[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = scr[4*i +: 4];
      end
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    scr_n      = scr;
    cnt_n      = cnt;
    busy_n     = busy;
    done_n     = 1'b0;
    bcd_n      = bcd_out;
    overflow_n = overflow;

    unique case (state)
      IDLE: begin
        if (start) begin
          sh_n    = bin_in;
          scr_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        // Adjust and shift happen in the same cycle: {adj, sh} << 1
        scr_n = {adj[4*SD-2:0], sh[WIDTH-1]};
        sh_n  = {sh[WIDTH-2:0], 1'b0};
        cnt_n = cnt + CW'(1);

        if (cnt == CW'(WIDTH - 1)) begin
          // Result is taken from this final iteration's scratch value
          if (|scr_n[4*SD-1:4*DIGITS]) begin
            bcd_n      = {DIGITS{4'h9}};
            overflow_n = 1'b1;
          end else begin
            bcd_n      = scr_n[4*DIGITS-1:0];
            overflow_n = 1'b0;
          end
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      scr      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      scr      <= scr_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      bcd_out  <= bcd_n;
      overflow <= overflow_n;
    end
  end

endmodule

// File: tb/tb_conversaodec_bin_seq.sv
// Directed testbench for conversaodec_bin_seq: latency, handshake, saturation,
// ignored restarts, back-to-back operation, mid-conversion reset and value checks.
module tb_conversaodec_bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  conversaodec_bin_seq #(.WIDTH(16), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 9999
  function automatic logic [16:0] ref_conv(input logic [15:0] v);
    int unsigned x;
    x = v;
    if (x > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Operand-entry side conversion: packed BCD back to binary
  function automatic logic [15:0] bcd2bin(input logic [15:0] b);
    int unsigned r;
    r = b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
    return 16'(r);
  endfunction

  // Present a value with start for exactly one accepting edge
  task automatic launch(input logic [15:0] v);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count negedges until done; optionally poke a second start at cycle poke_at
  task automatic wait_done(input int poke_at, output int lat, output int busy_cnt,
                           output int changes);
    logic [15:0] prev;
    prev     = bcd_out;
    lat      = 0;
    busy_cnt = 0;
    changes  = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == poke_at) begin
        start  = 1'b1;
        bin_in = 16'h0063;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) break;
      if (bcd_out !== prev) changes++;
    end
    start = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [15:0] v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat, bc, ch;
    launch(v);
    wait_done(0, lat, bc, ch);
    chk({tag, "_latency"}, lat, 17);
    chk({tag, "_bcd"}, bcd_out, exp_bcd);
    chk({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  initial begin
    int lat, bc, ch;
    logic [16:0] r;
    logic [15:0] v;

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_bcd", bcd_out, 16'h0000);
    chk("reset_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    convert("zero", 16'h0000, 16'h0000, 1'b0);

    // 1234 with handshake timing checks
    launch(16'h04D2);
    wait_done(0, lat, bc, ch);
    chk("b1234_latency", lat, 17);
    chk("b1234_busy_cycles", bc, 16);
    chk("b1234_no_intermediate", ch, 0);
    chk("b1234_bcd", bcd_out, 16'h1234);
    chk("b1234_ovf", overflow, 0);
    chk("b1234_busy_at_done", busy, 0);
    @(negedge clk);
    chk("b1234_done_width", done, 0);
    chk("b1234_hold", bcd_out, 16'h1234);

    convert("b9999", 16'h270F, 16'h9999, 1'b0);
    convert("b10000", 16'h2710, 16'h9999, 1'b1);
    convert("bffff", 16'hFFFF, 16'h9999, 1'b1);
    convert("b0100", 16'h0064, 16'h0100, 1'b0);

    // Second start during busy must be ignored
    launch(16'h0010);
    wait_done(5, lat, bc, ch);
    chk("ignore_latency", lat, 17);
    chk("ignore_bcd", bcd_out, 16'h0016);
    chk("ignore_ovf", overflow, 0);
    @(negedge clk);
    chk("ignore_idle_after", busy, 0);

    // Back-to-back with start held high
    @(negedge clk);
    bin_in = 16'd42;
    start  = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("b2b_first_latency", lat, 17);
    chk("b2b_first_bcd", bcd_out, 16'h0042);
    bin_in = 16'd7;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("b2b_second_latency", lat, 17);
    chk("b2b_second_bcd", bcd_out, 16'h0007);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset mid-conversion
    launch(16'h1F40);
    repeat (8) @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_bcd", bcd_out, 16'h0000);
    chk("rstmid_ovf", overflow, 0);
    chk("rstmid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    bc = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) bc++;
    end
    chk("rstmid_no_done", bc, 0);

    // Round trip through the BCD-to-binary conversion
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom_range(0, 9999));
      launch(v);
      wait_done(0, lat, bc, ch);
      chk("roundtrip_latency", lat, 17);
      chk("roundtrip_value", bcd2bin(bcd_out), v);
      chk("roundtrip_ovf", overflow, 0);
    end

    // Full-range values against the reference model
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom_range(0, 65535));
      r = ref_conv(v);
      launch(v);
      wait_done(0, lat, bc, ch);
      chk("random_latency", lat, 17);
      chk("random_bcd", bcd_out, r[15:0]);
      chk("random_ovf", overflow, r[16]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
